// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
// Holds the clear-engine state encoding and the default geometry used by
// the core's top-level register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine for the register file.
// Walks the register index space one entry per cycle, then signals
// completion with a single-cycle pulse.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   clr_req     - start a clear (pulse or level; sampled only when idle)
//   idle        - engine idle; normal writes/reserves/bypass allowed
//   clr_busy    - engine active (CLEAR or DONE)
//   clr_done    - one-cycle completion pulse
//   clr_we      - clear strobe into the array
//   clr_addr    - register currently being cleared
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          idle,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // Register 0 needs no clearing when it is hard-wired, so start at 1.
  localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The terminal index is tested explicitly, so the counter never wraps
  // while clearing; it is parked at zero once the walk finishes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idle      = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    clr_we    = 1'b0;
    unique case (state)
      IDLE: begin
        idle = 1'b1;
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = FIRST;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      DONE: begin
        clr_busy  = 1'b1;
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read register file with busy scoreboard and a
// sequential bulk-clear engine. Sits between decode (read/reserve) and
// writeback (write/release).
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   write/wrAddr/wrData - write port; a write also releases the busy bit
//   rdAddr/rdData     - NREAD packed combinational read ports
//   rdBusy            - scoreboard busy bit per read port
//   rsv/rsvAddr       - mark a register busy
//   clrReq            - start bulk clear
//   clrBusy/clrDone   - clear engine active / completion pulse
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write,
  input  logic [AW-1:0]          wrAddr,
  input  logic [WIDTH-1:0]       wrData,
  input  logic [NREAD*AW-1:0]    rdAddr,
  output logic [NREAD*WIDTH-1:0] rdData,
  output logic [NREAD-1:0]       rdBusy,
  input  logic                   rsv,
  input  logic [AW-1:0]          rsvAddr,
  input  logic                   clrReq,
  output logic                   clrBusy,
  output logic                   clrDone
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] sb;

  logic          idle;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_ok;
  logic          rsv_ok;
  logic          bypass_on;

  regfile_clr_fsm #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clrReq),
    .idle     (idle),
    .clr_busy (clrBusy),
    .clr_done (clrDone),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes and reservations are only honoured while the clear engine is idle.
  assign wr_ok     = write && idle && !((ZERO_REG != 0) && (wrAddr == '0));
  assign rsv_ok    = rsv && idle && !((ZERO_REG != 0) && (rsvAddr == '0));
  assign bypass_on = (BYPASS != 0) && write && idle;

  // The reservation is applied after the write release so that a
  // same-cycle reserve of the written register leaves it busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      sb <= '0;
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
      sb[clr_addr]   <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[wrAddr] <= wrData;
        sb[wrAddr]   <= 1'b0;
      end
      if (rsv_ok) sb[rsvAddr] <= 1'b1;
    end
  end

  // Read priority: hard-wired zero, then same-cycle write forwarding,
  // then the stored value. A forwarded write also hides the busy bit.
  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          hit;

    assign addr    = rdAddr[i*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = bypass_on && (wrAddr == addr);

    assign rdData[i*WIDTH +: WIDTH] = is_zero ? '0 : (hit ? wrData : regs[addr]);
    assign rdBusy[i]                = !is_zero && !hit && sb[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb. Two instances run side by side:
// instance 0 uses the default geometry (32x32, 2 reads, bypass, zero reg),
// instance 1 the reduced sweep (16-bit, 8 deep, 4 reads, no bypass, no zero reg).
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset;

  logic        in_write [2];
  logic [4:0]  in_wa    [2];
  logic [31:0] in_wd    [2];
  logic [4:0]  in_ra    [2][4];
  logic        in_rsv   [2];
  logic [4:0]  in_rsva  [2];
  logic        in_clr   [2];

  logic [63:0] a_rd;
  logic [1:0]  a_busy;
  logic        a_cb, a_cd;
  logic [63:0] b_rd;
  logic [3:0]  b_busy;
  logic        b_cb, b_cd;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state: register contents, busy bits, and the number
  // of cycles elapsed since a clear started (-1 when no clear is running).
  logic [31:0] m_reg   [2][32];
  bit          m_sb    [2][32];
  int          m_phase [2];

  always #5 clk = ~clk;

  regfile_sb #(
    .WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_a (
    .clk     (clk),
    .reset   (reset),
    .write   (in_write[0]),
    .wrAddr  (in_wa[0]),
    .wrData  (in_wd[0]),
    .rdAddr  ({in_ra[0][1], in_ra[0][0]}),
    .rdData  (a_rd),
    .rdBusy  (a_busy),
    .rsv     (in_rsv[0]),
    .rsvAddr (in_rsva[0]),
    .clrReq  (in_clr[0]),
    .clrBusy (a_cb),
    .clrDone (a_cd)
  );

  regfile_sb #(
    .WIDTH(16), .DEPTH(8), .NREAD(4), .BYPASS(0), .ZERO_REG(0)
  ) dut_b (
    .clk     (clk),
    .reset   (reset),
    .write   (in_write[1]),
    .wrAddr  (in_wa[1][2:0]),
    .wrData  (in_wd[1][15:0]),
    .rdAddr  ({in_ra[1][3][2:0], in_ra[1][2][2:0], in_ra[1][1][2:0], in_ra[1][0][2:0]}),
    .rdData  (b_rd),
    .rdBusy  (b_busy),
    .rsv     (in_rsv[1]),
    .rsvAddr (in_rsva[1][2:0]),
    .clrReq  (in_clr[1]),
    .clrBusy (b_cb),
    .clrDone (b_cd)
  );

  // Per-instance configuration
  function automatic int dep(int d);  return (d == 0) ? 32 : 8;  endfunction
  function automatic int zro(int d);  return (d == 0) ? 1 : 0;   endfunction
  function automatic int byp(int d);  return (d == 0) ? 1 : 0;   endfunction
  function automatic int nrd(int d);  return (d == 0) ? 2 : 4;   endfunction
  function automatic logic [31:0] msk(int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction
  // Registers that the clear walk visits
  function automatic int nclr(int d); return dep(d) - zro(d); endfunction

  function automatic logic [31:0] dut_rd(int d, int i);
    if (d == 0) return a_rd[i*32 +: 32];
    return {16'h0, b_rd[i*16 +: 16]};
  endfunction
  function automatic logic dut_busy(int d, int i);
    return (d == 0) ? a_busy[i] : b_busy[i];
  endfunction
  function automatic logic dut_cb(int d); return (d == 0) ? a_cb : b_cb; endfunction
  function automatic logic dut_cd(int d); return (d == 0) ? a_cd : b_cd; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[d][r] = '0;
        m_sb[d][r]  = 1'b0;
      end
      m_phase[d] = -1;
    end
  endtask

  // Expected outputs derived from model state plus the current inputs
  task automatic checkOutput();
    int          ra;
    bit          idle;
    logic [31:0] ed;
    logic        eb;
    if (!reset) modelReset();
    for (int d = 0; d < 2; d++) begin
      idle = (m_phase[d] < 0);
      for (int i = 0; i < nrd(d); i++) begin
        ra = int'(in_ra[d][i]);
        if (zro(d) != 0 && ra == 0) begin
          ed = '0;
          eb = 1'b0;
        end else if (byp(d) != 0 && in_write[d] && idle && int'(in_wa[d]) == ra) begin
          ed = in_wd[d] & msk(d);
          eb = 1'b0;
        end else begin
          ed = m_reg[d][ra];
          eb = m_sb[d][ra];
        end
        check($sformatf("inst%0d rdData%0d@%0d", d, i, ra), dut_rd(d, i), ed);
        check($sformatf("inst%0d rdBusy%0d@%0d", d, i, ra), 32'(dut_busy(d, i)), 32'(eb));
      end
      check($sformatf("inst%0d clrBusy", d), 32'(dut_cb(d)), 32'(m_phase[d] >= 0));
      check($sformatf("inst%0d clrDone", d), 32'(dut_cd(d)), 32'(m_phase[d] == nclr(d)));
    end
  endtask

  // Advance the model across one rising edge
  task automatic updateModel();
    if (!reset) begin
      modelReset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (m_phase[d] < 0) begin
        if (in_write[d] && !(zro(d) != 0 && in_wa[d] == 0)) begin
          m_reg[d][in_wa[d]] = in_wd[d] & msk(d);
          m_sb[d][in_wa[d]]  = 1'b0;
        end
        if (in_rsv[d] && !(zro(d) != 0 && in_rsva[d] == 0)) m_sb[d][in_rsva[d]] = 1'b1;
        if (in_clr[d]) m_phase[d] = 0;
      end else if (m_phase[d] < nclr(d)) begin
        m_reg[d][zro(d) + m_phase[d]] = '0;
        m_sb[d][zro(d) + m_phase[d]]  = 1'b0;
        m_phase[d]++;
      end else begin
        m_phase[d] = -1;
      end
    end
  endtask

  // Compare process: check on every cycle, update model on every edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      checkOutput();
      @(posedge clk);
      updateModel();
    end
  end

  task automatic clearInputs();
    for (int d = 0; d < 2; d++) begin
      in_write[d] = 1'b0;
      in_wa[d]    = '0;
      in_wd[d]    = '0;
      in_rsv[d]   = 1'b0;
      in_rsva[d]  = '0;
      in_clr[d]   = 1'b0;
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    clearInputs();
  endtask

  function automatic logic [4:0] pickAddr(int d);
    if (d == 0 && $urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, dep(d) - 1));
  endfunction

  task automatic applyStimulus();
    nextCycle();
    reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_write[d] = 1'($urandom_range(0, 1));
      in_wa[d]    = pickAddr(d);
      in_wd[d]    = $urandom;
      in_rsv[d]   = ($urandom_range(0, 3) == 0);
      in_rsva[d]  = pickAddr(d);
      in_clr[d]   = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 4; i++)
        in_ra[d][i] = ($urandom_range(0, 3) == 0) ? in_wa[d] : pickAddr(d);
    end
  endtask

  // Runs one clear on instance d and counts cycles with clrBusy high.
  // Optionally issues a write to reg3 or pulls reset at a given clear cycle.
  task automatic runClear(input int d, input int abort_at, input int wr_at,
                          output int busy_n, output logic done_last);
    nextCycle();
    in_clr[d] = 1'b1;
    busy_n    = 0;
    done_last = 1'b0;
    for (int k = 0; k < 100; k++) begin
      nextCycle();
      if (k == wr_at) begin
        in_write[d] = 1'b1;
        in_wa[d]    = 5'd3;
        in_wd[d]    = 32'h77;
      end
      if (k == abort_at) reset = 1'b0;
      #4;
      if (!dut_cb(d)) break;
      busy_n++;
      done_last = dut_cd(d);
    end
    if (!reset) begin
      nextCycle();
      reset = 1'b1;
    end
  endtask

  int   busy_n;
  logic done_last;

  initial begin
    reset = 1'b0;
    clearInputs();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) in_ra[d][i] = '0;

    // Reset state
    in_ra[0][0] = 5'd5;
    in_ra[0][1] = 5'd31;
    repeat (2) @(negedge clk);
    #4;
    check("reset rd0@5", dut_rd(0, 0), 32'h0);
    check("reset rd1@31", dut_rd(0, 1), 32'h0);
    check("reset busy", 32'(a_busy), 32'h0);

    // First write, readable next cycle
    nextCycle();
    reset       = 1'b1;
    in_write[0] = 1'b1;
    in_wa[0]    = 5'd5;
    in_wd[0]    = 32'hDEAD_BEEF;
    nextCycle();
    #4;
    check("write reg5", dut_rd(0, 0), 32'hDEAD_BEEF);

    // Hard-wired zero on inst0; ordinary reg0 on inst1
    nextCycle();
    in_write[0] = 1'b1; in_wa[0] = 5'd0; in_wd[0] = 32'hFFFF_FFFF; in_ra[0][0] = 5'd0;
    in_write[1] = 1'b1; in_wa[1] = 5'd0; in_wd[1] = 32'h1;          in_ra[1][0] = 5'd0;
    #4;
    check("zero reg same cycle", dut_rd(0, 0), 32'h0);
    check("inst1 reg0 no bypass", dut_rd(1, 0), 32'h0);
    nextCycle();
    in_write[1] = 1'b1; in_wa[1] = 5'd7; in_wd[1] = 32'hAA;
    #4;
    check("zero reg after write", dut_rd(0, 0), 32'h0);
    check("inst1 reg0 written", dut_rd(1, 0), 32'h1);

    // Bypass present on inst0, absent on inst1
    nextCycle();
    in_write[0] = 1'b1; in_wa[0] = 5'd7; in_wd[0] = 32'h1234_5678; in_ra[0][1] = 5'd7;
    in_write[1] = 1'b1; in_wa[1] = 5'd7; in_wd[1] = 32'h1234;      in_ra[1][1] = 5'd7;
    #4;
    check("bypass reg7", dut_rd(0, 1), 32'h1234_5678);
    check("no bypass reg7", dut_rd(1, 1), 32'h00AA);
    nextCycle();
    #4;
    check("inst1 reg7 after", dut_rd(1, 1), 32'h1234);

    // Scoreboard: reserve, release by write, reserve+write
    nextCycle();
    in_rsv[0] = 1'b1; in_rsva[0] = 5'd9; in_ra[0][0] = 5'd9;
    nextCycle();
    #4;
    check("rsv reg9 busy", 32'(a_busy[0]), 32'h1);
    nextCycle();
    in_write[0] = 1'b1; in_wa[0] = 5'd9; in_wd[0] = 32'hA5;
    #4;
    check("reg9 busy hidden by bypass", 32'(a_busy[0]), 32'h0);
    check("reg9 bypass data", dut_rd(0, 0), 32'hA5);
    nextCycle();
    #4;
    check("reg9 released", 32'(a_busy[0]), 32'h0);
    nextCycle();
    in_write[0] = 1'b1; in_wa[0] = 5'd9; in_wd[0] = 32'h5A;
    in_rsv[0]   = 1'b1; in_rsva[0] = 5'd9;
    nextCycle();
    #4;
    check("rsv+write busy", 32'(a_busy[0]), 32'h1);
    check("rsv+write data", dut_rd(0, 0), 32'h5A);

    // Fill and clear inst0, with a write lost mid-clear
    for (int r = 1; r < 32; r++) begin
      nextCycle();
      in_write[0] = 1'b1; in_wa[0] = 5'(r); in_wd[0] = 32'h1000_0000 | r;
      in_rsv[0]   = r[0]; in_rsva[0] = 5'(31 - r);
    end
    runClear(0, -1, 5, busy_n, done_last);
    check("inst0 clear busy cycles", 32'(busy_n), 32'd32);
    check("inst0 clrDone on last", 32'(done_last), 32'h1);
    for (int r = 0; r < 32; r++) begin
      nextCycle();
      in_ra[0][0] = 5'(r);
      in_ra[0][1] = 5'(31 - r);
      #4;
      check($sformatf("cleared reg%0d", r), dut_rd(0, 0), 32'h0);
      check($sformatf("cleared busy%0d", r), 32'(a_busy), 32'h0);
    end
    nextCycle();
    in_ra[0][0] = 5'd3;
    #4;
    check("mid-clear write lost", dut_rd(0, 0), 32'h0);

    // Reset in the middle of a clear
    for (int r = 18; r < 32; r++) begin
      nextCycle();
      in_write[0] = 1'b1; in_wa[0] = 5'(r); in_wd[0] = 32'hC0DE_0000 | r;
    end
    runClear(0, 10, -1, busy_n, done_last);
    check("abort after 10 cycles", 32'(busy_n), 32'd10);
    nextCycle();
    in_ra[0][0] = 5'd20;
    in_ra[0][1] = 5'd31;
    #4;
    check("abort zeroed reg20", dut_rd(0, 0), 32'h0);
    check("abort zeroed reg31", dut_rd(0, 1), 32'h0);
    check("abort clrBusy low", 32'(a_cb), 32'h0);
    runClear(0, -1, -1, busy_n, done_last);
    check("inst0 full clear after abort", 32'(busy_n), 32'd32);

    // Clear on the 8-deep instance without zero register
    for (int r = 0; r < 8; r++) begin
      nextCycle();
      in_write[1] = 1'b1; in_wa[1] = 5'(r); in_wd[1] = 32'h100 + r;
    end
    runClear(1, -1, -1, busy_n, done_last);
    check("inst1 clear busy cycles", 32'(busy_n), 32'd9);
    check("inst1 clrDone on last", 32'(done_last), 32'h1);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) applyStimulus();

    nextCycle();
    reset = 1'b1;
    nextCycle();
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the MIPS core's 32x32 two-read register file.
- Features:
  - configurable width, depth and number of read ports
  - writes on the rising edge
  - optional write-to-read bypass
  - hard-wired zero register
  - per-register busy scoreboard for long-latency results (mult/div, loads)
  - sequential bulk-clear engine
- Sits between decode (read/reserve) and writeback (write/release) in the pipelined datapath.

Parameters:
- WIDTH, 32: data width of each register.
- DEPTH, 32: number of registers; power of two, >= 4. AW = $clog2(DEPTH) is a derived localparam.
- NREAD, 2: number of independent read ports, 1..4.
- BYPASS, 1: when 1, the same-cycle write is forwarded to matching reads.
- ZERO_REG, 1: when 1, register 0 always reads 0 and ignores writes and reservations.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 asserts).
- write  in  1  write enable.
- wrAddr  in  AW  write address.
- wrData  in  WIDTH  write data.
- rdAddr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdData  out  NREAD*WIDTH  read data; port i occupies bits [i*WIDTH +: WIDTH].
- rdBusy  out  NREAD  scoreboard busy bit for each read address.
- rsv  in  1  reserve request: mark rsvAddr busy.
- rsvAddr  in  AW  register to reserve.
- clrReq  in  1  start bulk clear (one-cycle pulse or level).
- clrBusy  out  1  clear engine active.
- clrDone  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0
  - all scoreboard bits = 0
  - FSM = IDLE, counter = 0
  - clrBusy = 0, clrDone = 0
  - rdData follows the zeroed array combinationally.
- Write:
  - At the rising edge, if write=1 and the FSM is IDLE, reg[wrAddr] <= wrData and sb[wrAddr] <= 0.
  - With ZERO_REG=1, wrAddr=0 is dropped.
- Read: combinational, zero latency. rdData_i is selected in priority order:
  - 0 if ZERO_REG and rdAddr_i==0;
  - else wrData if BYPASS and write and FSM IDLE and wrAddr==rdAddr_i;
  - else reg[rdAddr_i].
- Read ports are fully independent; identical addresses on several ports are legal.
- Scoreboard:
  - At the rising edge, rsv=1 and FSM IDLE sets sb[rsvAddr]. rsvAddr=0 is ignored when ZERO_REG=1.
  - rsv and write to the same address in the same cycle: set wins, so the bit ends at 1 and the data is still written.
- rdBusy_i:
  - = sb[rdAddr_i]
  - cleared combinationally when BYPASS and a same-cycle write matches rdAddr_i
  - always 0 for address 0 when ZERO_REG=1.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clrReq=1. The counter loads 1 if ZERO_REG=1, else 0.
  - CLEAR: each cycle reg[cnt] <= 0 and sb[cnt] <= 0, then cnt++. At cnt==DEPTH-1 (after writing it) -> DONE.
  - DONE: clrDone=1 for exactly one cycle, then -> IDLE.
  - clrBusy=1 in CLEAR and DONE.
  - Clear latency: with ZERO_REG=1, DEPTH-1 CLEAR cycles + 1 DONE cycle.
- While clrBusy=1:
  - write and rsv are discarded; no queueing.
  - clrReq is ignored.
  - Reads return current array contents, i.e. partially cleared data.
  - Bypass is disabled.
- Reset mid-clear: aborts immediately to IDLE with the array zeroed.
- The counter is AW bits wide; no wrap-around occurs because the terminal test is explicit.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2)
  - the default WIDTH/DEPTH constants used by the core top level.
- Sub-module: regfile_clr_fsm.
  - Contains the state register, counter and clrBusy/clrDone generation.
  - Drives a clear-write strobe and address into the array.
- The array, bypass muxes and scoreboard stay in regfile_sb.

Test Plan:
- Reset then read, defaults:
  - Hold reset=0; read ports 0,1 at addresses 5 and 31 -> rdData=0, rdBusy=0.
  - Release reset; write reg5=32'hDEADBEEF -> next cycle port0@5 reads 32'hDEADBEEF.
- Zero register and bypass:
  - Write reg0=32'hFFFFFFFF -> reading reg0 gives 0.
  - In the same cycle as write reg7=32'h12345678, port1@7 gives 32'h12345678 (BYPASS=1) and the old value (BYPASS=0).
- Scoreboard:
  - rsv reg9 -> rdBusy for reg9 = 1 next cycle.
  - Later write reg9=32'hA5 -> rdBusy 0 in the write cycle (bypass), and sb=0 afterwards.
  - rsv+write reg9 in the same cycle -> sb=1 and the data updated.
- Clear:
  - Fill regs 1..31 with nonzero values; pulse clrReq -> clrBusy high for 32 cycles with clrDone on the last.
  - After completion all reads are 0 and all rdBusy are 0.
  - A write to reg3 issued mid-clear is lost.
- Reset mid-clear:
  - Assert reset=0 at clear cycle 10 -> clrBusy=0 immediately, all regs 0.
  - After release, a new clrReq runs the full clear.
- Parameter sweep: WIDTH=16, DEPTH=8, NREAD=4, ZERO_REG=0.
  - Write reg0=16'h1 -> reads 16'h1.
  - Clear takes 8 CLEAR cycles + DONE.
